// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
// Build option ALU_SCHED_FIXED_PRIO_EN (used in alu_sched_arb) selects fixed priority arbitration.
package alu_sched_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    localparam logic ALU_OP_ADD = 1'b1;
    localparam logic ALU_OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } sched_state_e;

endpackage

// File: rtl/alu_sched_arb.sv
// N-way request arbiter with a rotating start pointer.
// Build option ALU_SCHED_FIXED_PRIO_EN: when defined, the lowest valid index always wins
// and the pointer stays at 0. Otherwise it is round-robin, with the pointer moving past each winner.
module alu_sched_arb
    import alu_sched_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic           found;

    // Search starts at ptr_q and wraps. In fixed-priority builds ptr_q is always 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N]) begin
                found                        = 1'b1;
                grant[(int'(ptr_q) + i) % N] = 1'b1;
                grant_idx                    = IDW'((int'(ptr_q) + i) % N);
            end
        end
    end

    // Pointer moves to the slot after the winner when a grant is taken.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            ptr_d = '0;
`else
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
`endif
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one registered add/sub ALU among N requesters, with one operation in flight at a time.
// Build option ALU_SCHED_FIXED_PRIO_EN (see alu_sched_arb) selects fixed priority instead of round-robin.
//
//  state | meaning
//  IDLE  | waiting; the arbiter winner sees req_ready and its operands are latched
//  EXEC  | operand regs drive the ALU; the ALU registers Y at the end of this cycle
//  CAPT  | ALU result is latched into the response register
//  RESP  | response presented; held until rsp_ready
module alu_req_sched
    import alu_sched_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_ctrl,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_control,
    input  logic [W-1:0]   alu_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [IDW-1:0] rsp_id,
    output logic           busy
);

    sched_state_e   state_q;
    sched_state_e   state_d;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           ctrl_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   rsp_data_q;

    alu_sched_arb #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_valid) state_d = EXEC;
            EXEC:    state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs. req_ready is forced low while reset is asserted, even in IDLE.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    req_ready = grant;
                    accept    = |req_valid;
                end
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand/id capture on accept, and result capture in CAPT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= ALU_OP_SUB;
            id_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                a_q    <= req_a[int'(grant_idx) * W +: W];
                b_q    <= req_b[int'(grant_idx) * W +: W];
                ctrl_q <= req_ctrl[grant_idx];
                id_q   <= grant_idx;
            end
            if (state_q == CAPT) begin
                rsp_data_q <= alu_y;
            end
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = ctrl_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = id_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// Testbench for alu_req_sched with a registered add/sub ALU attached.
// Honours ALU_SCHED_FIXED_PRIO_EN to select the expected arbitration order.
module tb_alu_req_sched;
    import alu_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ctrl;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_control;
    logic [W-1:0]   alu_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_req_sched #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_y       (alu_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    // The shared ALU: one-cycle registered add/sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alu_y <= '0;
        else     alu_y <= alu_control ? alu_a + alu_b : alu_a - alu_b;
    end

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        req_valid[i]      = v;
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
        req_ctrl[i]       = c;
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_grant(input int i, input string nm);
        int cyc;
        cyc = 0;
        while (req_ready[i] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk(nm, {28'd0, req_ready}, 32'd1 << i);
    endtask

    // Returns the number of cycles waited; the caller checks it.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        set_req(v.idx, 1'b1, v.a, v.b, v.c);
        rsp_ready = 1'b1;
        #1;
        wait_grant(v.idx, {nm, "_grant"});
        tick();
        req_valid[v.idx] = 1'b0;
        #1;
        chk({nm, "_alu_a"}, alu_a, v.a);
        chk({nm, "_alu_b"}, alu_b, v.b);
        chk({nm, "_alu_ctrl"}, alu_control, v.c);
        wait_rsp(lat);
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_data"}, rsp_data, v.exp);
        chk({nm, "_id"}, rsp_id, v.idx);
        tick();
        chk({nm, "_done"}, {busy, rsp_valid}, 2'b00);
    endtask

    function automatic int ref_result(input int a, input int b, input bit add);
        return add ? (a + b) % 16 : (a - b + 16) % 16;
    endfunction

    initial begin
        int k, last, lat, cyc;
        logic [3:0] exp_rdy;
        int m_phase, m_ptr, m_id, m_res, m_data, m_a, m_b, m_c, w;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_alu_ops", {alu_a, alu_b}, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        vecs[0] = '{0, 4'h3, 4'h4, ALU_OP_ADD, 4'h7};
        vecs[1] = '{2, 4'h2, 4'h5, ALU_OP_SUB, 4'hD};
        vecs[2] = '{1, 4'hF, 4'h1, ALU_OP_ADD, 4'h0};
        vecs[3] = '{3, 4'h9, 4'h9, ALU_OP_ADD, 4'h2};
        vecs[4] = '{1, 4'h0, 4'h1, ALU_OP_SUB, 4'hF};
        vecs[5] = '{2, 4'h8, 4'h8, ALU_OP_SUB, 4'h0};
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // All requesters held valid: grant order and accept spacing.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(i), 4'h1, ALU_OP_ADD);
        #1;
        k = 0;
        last = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            if (req_ready != 4'b0000) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
                chk($sformatf("all_grant%0d", k), req_ready, 4'b0001);
`else
                chk($sformatf("all_grant%0d", k), {28'd0, req_ready}, 32'd1 << (k % N));
`endif
                if (k > 0) chk($sformatf("all_spacing%0d", k), c - last, 4);
                last = c;
                k++;
            end
            tick();
        end
        chk("all_accepts", k, 5);

        // Response back-pressure.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'h6, 4'h7, ALU_OP_ADD);
        #1;
        wait_grant(0, "bp_grant");
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'h1, 4'h2, ALU_OP_ADD);
        set_req(2, 1'b1, 4'h3, 4'h3, ALU_OP_ADD);
        #1;
        wait_rsp(lat);
        chk("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {27'd0, rsp_valid, rsp_data, rsp_id, req_ready},
                {27'd0, 1'b1, 4'hD, 2'd0, 4'b0000});
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_handshake_valid", rsp_valid, 1);
        tick();
        chk("bp_next_grant", req_ready, 4'b0010);
        tick();
        chk("bp_single_accept", {busy, req_ready}, 5'b10000);
        req_valid = '0;

        // Asynchronous reset while an operation is in EXEC.
        do_reset();
        set_req(2, 1'b1, 4'hA, 4'h3, ALU_OP_SUB);
        #1;
        wait_grant(2, "rst_grant");
        tick();
        req_valid = '0;
        set_req(1, 1'b1, 4'h5, 4'h5, ALU_OP_ADD);
        set_req(3, 1'b1, 4'h1, 4'h1, ALU_OP_ADD);
        #1;
        chk("rst_pre_state", {busy, alu_a, 2'b00, rsp_id}, {1'b1, 4'hA, 2'b00, 2'd2});
        rst = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_rsp", {rsp_valid, rsp_data, rsp_id}, 0);
        chk("rst_async_ready", req_ready, 0);
        chk("rst_async_ops", {alu_a, alu_b}, 0);
        tick();
        chk("rst_held_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_next_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        #1;
        wait_rsp(lat);
        chk("rst_post_latency", lat, 3);
        chk("rst_post_rsp", {rsp_data, 2'b00, rsp_id}, {4'hA, 2'b00, 2'd1});

        // Valid withdrawn before grant is not served.
        do_reset();
        set_req(2, 1'b1, 4'h1, 4'h1, ALU_OP_ADD);
        #1;
        wait_grant(2, "drop_first_grant");
        tick();
        req_valid[2] = 1'b0;
        set_req(3, 1'b1, 4'h7, 4'h7, ALU_OP_ADD);
        set_req(1, 1'b1, 4'h9, 4'h3, ALU_OP_SUB);
        #1;
        tick();
        req_valid[3] = 1'b0;
        #1;
        cyc = 0;
        while (req_ready == 4'b0000 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("drop_grant", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1;
        wait_rsp(lat);
        chk("drop_rsp", {rsp_valid, rsp_data, 2'b00, rsp_id}, {1'b1, 4'h6, 2'b00, 2'd1});
        tick();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drop_quiet%0d", i), {req_ready, rsp_valid, busy}, 6'b0);
            tick();
        end

        // Randomized traffic against a transaction-level reference.
        do_reset();
        m_phase = 0; m_ptr = 0; m_id = 0; m_res = 0; m_data = 0;
        m_a = 0; m_b = 0; m_c = 0; w = 0;
        for (int c = 0; c < 400; c++) begin
            exp_rdy = '0;
            if (m_phase == 0) begin
                for (int off = 0; off < N; off++) begin
                    if (req_valid[(m_ptr + off) % N] && exp_rdy == 4'b0000) begin
                        w = (m_ptr + off) % N;
                        exp_rdy[w] = 1'b1;
                    end
                end
            end
            chk("rnd_req_ready", req_ready, exp_rdy);
            chk("rnd_status", {busy, rsp_valid}, {m_phase != 0, m_phase == 3});
            chk("rnd_rsp", {rsp_data, 2'b00, rsp_id}, {4'(m_data), 2'b00, 2'(m_id)});
            if (m_phase == 1)
                chk("rnd_alu_drive", {alu_control, alu_a, alu_b}, {1'(m_c), 4'(m_a), 4'(m_b)});

            if (m_phase == 0 && exp_rdy != 4'b0000) begin
                m_id  = w;
                m_a   = int'(req_a[w*W +: W]);
                m_b   = int'(req_b[w*W +: W]);
                m_c   = int'(req_ctrl[w]);
                m_res = ref_result(m_a, m_b, m_c != 0);
`ifndef ALU_SCHED_FIXED_PRIO_EN
                m_ptr = (w + 1) % N;
`endif
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_data  = m_res;
                m_phase = 3;
            end else if (m_phase == 3 && rsp_ready) begin
                m_phase = 0;
            end

            tick();
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(i, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
